add_tree_pipe: RTL

- Parametrised, pipelined N-input signed adder tree.
- Successor to the two-input registered adder: generalised operand count and width, with a stream handshake and backpressure.
- One register level per tree level.
- Used in the DSP datapath for channel combining and accumulate-free summation ahead of the DUC/DDC scaling stages.

---
 rtl/add_tree_pkg.sv | 43 ++++
 rtl/add_tree_stage.sv | 70 +++++++
 rtl/add_tree_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/add_tree_pkg.sv
// add_tree_pkg
// Shared constants and elaboration-time helpers for the pipelined adder tree.
//   clog2      : ceiling log2 for parameter derivation
//   levelsOf   : tree depth (also the pipeline latency) for a given operand count
//   owidthOf   : full-precision output width for a given operand width/count
//   sat_signed : clamp a sign-extended value into a signed out_w-bit range
// Optional feature macro used by the tree: ADD_TREE_SAT_EN.
package add_tree_pkg;

  localparam int MAX_NUM_IN = 16;

  // Ceiling log2 with a fixed loop bound so it stays a clean constant function
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int levelsOf(input int numIn);
    return clog2(numIn);
  endfunction

  function automatic int owidthOf(input int width, input int numIn);
    return width + levelsOf(numIn);
  endfunction

  // A value already narrow enough passes through untouched
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int in_w, input int out_w);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    if (in_w <= out_w) return value;
    maxV = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    minV = -maxV - 64'sd1;
    if (value > maxV) return maxV;
    if (value < minV) return minV;
    return value;
  endfunction

endpackage

// File: rtl/add_tree_stage.sv
// add_tree_stage
// One level of the adder tree: N_PAIRS sign-extended pairwise adds feeding a
// registered valid/data/tlast slot with bubble-collapsing flow control.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_valid     : upstream slot holds a beat
//   i_data      : 2*N_PAIRS operands of IN_W bits, pair p at operands 2p and 2p+1
//   i_last      : upstream tlast
//   i_downEn    : downstream slot can take a beat this cycle
//   o_en        : this slot can take a beat this cycle (feeds the upstream enable)
//   o_valid     : this slot holds a beat
//   o_data      : N_PAIRS partial sums of IN_W+1 bits
//   o_last      : tlast travelling with this slot
module add_tree_stage
  import add_tree_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int N_PAIRS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic [2*N_PAIRS*IN_W-1:0]      i_data,
  input  logic                           i_last,
  input  logic                           i_downEn,
  output logic                           o_en,
  output logic                           o_valid,
  output logic [N_PAIRS*(IN_W+1)-1:0]    o_data,
  output logic                           o_last
);

  localparam int OUT_W = IN_W + 1;

  logic [N_PAIRS*OUT_W-1:0] w_sum;
  logic [N_PAIRS*OUT_W-1:0] r_data;
  logic                     r_valid;
  logic                     r_last;

  // One extra bit per add means the partial sum can never wrap
  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    logic [IN_W-1:0] w_a;
    logic [IN_W-1:0] w_b;
    assign w_a = i_data[(2*p)*IN_W +: IN_W];
    assign w_b = i_data[(2*p+1)*IN_W +: IN_W];
    assign w_sum[p*OUT_W +: OUT_W] = {w_a[IN_W-1], w_a} + {w_b[IN_W-1], w_b};
  end

  // An empty slot always accepts; a full one accepts only while it drains
  assign o_en = ~r_valid | i_downEn;

  // Data only loads with a real beat so a bubble leaves the old value in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (o_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_sum;
        r_last <= i_last;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/add_tree_pipe.sv
// add_tree_pipe
// Pipelined NUM_IN-input signed adder tree with a valid/ready stream on both
// sides. One register level per tree level; latency LEVELS cycles.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_tdata     : NUM_IN packed WIDTH-bit operands, operand k at [k*WIDTH +: WIDTH]
//   i_tlast     : sideband carried with the beat
//   i_tvalid    : input beat valid
//   i_tready    : tree can accept a beat
//   o_tdata     : sum (full precision, or clamped to WIDTH bits with saturation)
//   o_tlast     : delayed i_tlast
//   o_tvalid    : output beat valid
//   o_tready    : downstream accepts
//   o_overflow  : sticky clamp flag (tied 0 without saturation)
// Optional feature: define ADD_TREE_SAT_EN to clamp the result to WIDTH bits.
module add_tree_pipe
  import add_tree_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NUM_IN = 4,
  localparam int LEVELS = levelsOf(NUM_IN),
`ifdef ADD_TREE_SAT_EN
  localparam int OWIDTH = WIDTH
`else
  localparam int OWIDTH = owidthOf(WIDTH, NUM_IN)
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [OWIDTH-1:0]       o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    o_overflow
);

  localparam int NP     = 1 << LEVELS;
  localparam int FULL_W = WIDTH + LEVELS;

  logic [NP*WIDTH-1:0] w_padded;
  logic [FULL_W-1:0]   w_lastData;

  // Missing operands of a non-power-of-2 tree enter stage 0 as zeros
  always_comb begin
    w_padded = '0;
    w_padded[NUM_IN*WIDTH-1:0] = i_tdata;
  end

  // Each level reads the previous level's slot and the next level's enable
  for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
    localparam int IN_W    = WIDTH + s;
    localparam int N_PAIRS = NP >> (s + 1);

    logic [2*N_PAIRS*IN_W-1:0]   w_inData;
    logic                        w_inValid;
    logic                        w_inLast;
    logic [N_PAIRS*(IN_W+1)-1:0] w_data;
    logic                        w_valid;
    logic                        w_last;
    logic                        w_en;
    logic                        w_downEn;

    if (s == 0) begin : g_head
      assign w_inData  = w_padded;
      assign w_inValid = i_tvalid;
      assign w_inLast  = i_tlast;
    end else begin : g_body
      assign w_inData  = g_lvl[s-1].w_data;
      assign w_inValid = g_lvl[s-1].w_valid;
      assign w_inLast  = g_lvl[s-1].w_last;
    end

    if (s == LEVELS - 1) begin : g_tail
      assign w_downEn = o_tready;
    end else begin : g_mid
      assign w_downEn = g_lvl[s+1].w_en;
    end

    add_tree_stage #(
      .IN_W    (IN_W),
      .N_PAIRS (N_PAIRS)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (w_inValid),
      .i_data   (w_inData),
      .i_last   (w_inLast),
      .i_downEn (w_downEn),
      .o_en     (w_en),
      .o_valid  (w_valid),
      .o_data   (w_data),
      .o_last   (w_last)
    );
  end

  assign i_tready   = g_lvl[0].w_en;
  assign o_tvalid   = g_lvl[LEVELS-1].w_valid;
  assign o_tlast    = g_lvl[LEVELS-1].w_last;
  assign w_lastData = g_lvl[LEVELS-1].w_data;

`ifdef ADD_TREE_SAT_EN
  logic signed [63:0] w_fullExt;
  logic signed [63:0] w_satVal;
  logic               w_clamped;
  logic               r_overflow;

  // Clamp sits after the last register so the latency does not change
  assign w_fullExt = {{(64-FULL_W){w_lastData[FULL_W-1]}}, w_lastData};
  assign w_satVal  = sat_signed(w_fullExt, FULL_W, WIDTH);
  assign w_clamped = (w_satVal != w_fullExt);
  assign o_tdata   = w_satVal[WIDTH-1:0];

  // The flag only records beats that actually left the tree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (o_tvalid && o_tready && w_clamped) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_tdata    = w_lastData;
  assign o_overflow = 1'b0;
`endif

endmodule
